ast_mac_filter: RTL and testbench
=================================

Name: ast_mac_filter

Overview:
- Avalon-ST stage directly upstream of the packet store/resolver stage.
- Classifies each incoming Ethernet packet by destination MAC and generates the per-packet write-enable that the resolver samples with startofpacket.
- Forwards the stream through one registered stage with full backpressure.
- Checks packet framing and length, and keeps saturating statistics counters.

Parameters:
- AST_DWIDTH, 64, stream data width in bits; must be a multiple of 8, minimum 64.
- CHANNEL_WIDTH, 1, width of the channel field.
- MIN_PCKT_SIZE, 60, minimum legal packet length in bytes.
- MAX_PCKT_SIZE, 1514, maximum legal packet length in bytes.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- filter_en_i  in  1  1 enables MAC filtering; 0 accepts every packet.
- dst_mac_i  in  48  local MAC address; sampled on the sop handshake.
- ast_sink_if  avalon_st_if.sink  -  input stream (data, valid, ready, startofpacket, endofpacket, empty, channel).
- ast_src_if  avalon_st_if.src  -  output stream toward the resolver.
- wrken_o  out  1  accept flag for the packet currently on ast_src_if; drives the resolver's wrken_i.
- accept_cnt_o  out  CNT_WIDTH  count of accepted packets.
- reject_cnt_o  out  CNT_WIDTH  count of MAC-rejected packets.
- len_err_cnt_o  out  CNT_WIDTH  count of packets whose length is out of range.
- frame_err_cnt_o  out  CNT_WIDTH  count of framing errors.

Behaviour:
Reset
- While rst_ni is low, all outputs are 0 regardless of the clock: src valid, sop, eop, empty, channel, data, wrken_o and all counters.
- Sink ready is 0 during reset and 1 from the first clock after deassertion.
- Reset mid-packet discards the in-flight packet. The FSM returns to IDLE with no counter update.

Pipeline and handshake
- One register stage; latency 1 cycle from sink handshake to src valid.
- Sink handshake = sink valid & sink ready.
- sink ready = !src_valid | src_ready. Combinational from src ready; no skid buffer.
- The output register loads data, sop, eop, empty and channel on every sink handshake.
- src_valid holds until src_ready. Output fields must stay stable while valid & !ready.

Byte order
- Byte 0 is data[AST_DWIDTH-1 -: 8].
- The destination MAC is data[AST_DWIDTH-1 -: 48] of the sop beat.

Classification (on the sop handshake)
- hit = !filter_en_i | (mac == dst_mac_i) | (mac == 48'hFFFF_FFFF_FFFF).
- wrken_o is registered together with the sop beat and held constant until the beat after the eop beat leaves.
- wrken_o is 0 in IDLE.

Packet FSM (advances on sink handshakes only)
- IDLE:
  - beat without sop is dropped: not forwarded, frame_err++.
  - sop & eop: single-beat packet; length is checked, and the FSM stays in IDLE.
  - sop & !eop: go to PKT.
- PKT:
  - eop: go to IDLE.
  - sop: previous packet was unterminated. frame_err++; the new beat is forwarded as a new packet and re-classified. The old packet has no eop toward the resolver.

Length check
- Byte counter clears at sop.
- Adds AST_DWIDTH/8 per beat, except the eop beat adds AST_DWIDTH/8 - empty.
- The counter saturates at 2047.
- At eop, length < MIN_PCKT_SIZE or > MAX_PCKT_SIZE gives len_err++. The packet is still forwarded and wrken_o is unchanged.

Statistics
- At eop: accept_cnt++ if hit, else reject_cnt++.
- All counters saturate at all-ones.
- Simultaneous increments of different counters in one cycle are all applied.

Decomposition:
- Package mac_filter_pkg holds:
  - state enum typedef (IDLE, PKT);
  - BCAST_MAC constant;
  - MAC_WIDTH = 48;
  - a saturating-increment function.
- Sub-module sat_counter (parameter WIDTH; inputs inc_i, rst_ni) is instantiated four times.

Test Plan:
- Reset and idle: 1 cycle after rst_ni rises, sink ready = 1 and all counters = 0.
- MAC hit: filter_en=1, dst_mac=00:11:22:33:44:55, 8-beat packet with MAC 001122334455 and empty=4 (60 B).
  - src output is identical, 1 cycle later.
  - wrken_o=1 from sop through eop.
  - accept=1, len_err=0.
- Miss and broadcast:
  - MAC 001122334456 → wrken_o=0, reject=1.
  - MAC FFFFFFFFFFFF → wrken_o=1, accept=1.
  - filter_en=0 with any MAC → accept.
- Backpressure: src ready toggles 1-0-0-1 during a 190-beat packet with empty=6 (1514 B).
  - No beat is lost or duplicated and outputs stay stable while stalled.
  - len_err stays 0; a 191-beat packet gives len_err=1.
- Framing errors:
  - sop, 2 beats, then a new sop without eop → frame_err=1 and the second packet is classified.
  - Beat without sop in IDLE → dropped, frame_err=2.
- Async reset mid-packet: rst_ni low at beat 3 → outputs are 0 immediately; the next clean packet is handled normally.

Source files
------------

// File: rtl/ast_mac_filter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mac_filter_pkg : shared types, constants and helpers for ast_mac_filter.
// Rev 1.0
// -----------------------------------------------------------------------------
package mac_filter_pkg;

    localparam int MAC_WIDTH = 48;
    localparam logic [MAC_WIDTH-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_e;

    // Increments val, holding at the all-ones value of a width-bit counter (width <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ast_mac_filter_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// avalon_st_if : Avalon-ST packet stream bundle with sink/src views.
// Rev 1.0
// -----------------------------------------------------------------------------
interface avalon_st_if #(
    parameter int DWIDTH        = 64,
    parameter int CHANNEL_WIDTH = 1
);
    localparam int EMPTY_WIDTH = $clog2(DWIDTH / 8);

    logic [DWIDTH-1:0]        data;
    logic                     valid;
    logic                     ready;
    logic                     startofpacket;
    logic                     endofpacket;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [CHANNEL_WIDTH-1:0] channel;

    modport sink (
        input  data, valid, startofpacket, endofpacket, empty, channel,
        output ready
    );

    modport src (
        output data, valid, startofpacket, endofpacket, empty, channel,
        input  ready
    );

endinterface
`default_nettype wire

// File: rtl/ast_mac_filter_sat_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sat_counter : event counter that sticks at all-ones instead of wrapping.
// Rev 1.0
// -----------------------------------------------------------------------------
module sat_counter
    import mac_filter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             inc_i,
    output logic [WIDTH-1:0]      count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = WIDTH'(sat_inc(64'(count_q), WIDTH));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ast_mac_filter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ast_mac_filter : one-stage Avalon-ST forwarder with destination-MAC
//                  classification, framing/length checks and statistics.
// Rev 1.0
// -----------------------------------------------------------------------------
module ast_mac_filter
    import mac_filter_pkg::*;
#(
    parameter int AST_DWIDTH    = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int MIN_PCKT_SIZE = 60,
    parameter int MAX_PCKT_SIZE = 1514,
    parameter int CNT_WIDTH     = 32
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    input  wire logic                 filter_en_i,
    input  wire logic [MAC_WIDTH-1:0] dst_mac_i,
    avalon_st_if.sink                 ast_sink_if,
    avalon_st_if.src                  ast_src_if,
    output logic                      wrken_o,
    output logic [CNT_WIDTH-1:0]      accept_cnt_o,
    output logic [CNT_WIDTH-1:0]      reject_cnt_o,
    output logic [CNT_WIDTH-1:0]      len_err_cnt_o,
    output logic [CNT_WIDTH-1:0]      frame_err_cnt_o
);

    localparam int BEAT_BYTES  = AST_DWIDTH / 8;
    localparam int EMPTY_WIDTH = $clog2(BEAT_BYTES);
    localparam int LEN_WIDTH   = 11;
    localparam int LEN_SUM_W   = LEN_WIDTH + 1;

    localparam logic [LEN_WIDTH-1:0] LEN_SAT  = '1;
    localparam logic [LEN_WIDTH-1:0] MIN_LEN  = LEN_WIDTH'(MIN_PCKT_SIZE);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(MAX_PCKT_SIZE);
    localparam logic [LEN_SUM_W-1:0] BEAT_LEN = LEN_SUM_W'(BEAT_BYTES);

    state_e                   state_q, state_d;
    logic                     rdy_en_q, rdy_en_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic                     hit_q, hit_d;
    logic                     src_valid_q, src_valid_d;
    logic [AST_DWIDTH-1:0]    src_data_q, src_data_d;
    logic                     src_sop_q, src_sop_d;
    logic                     src_eop_q, src_eop_d;
    logic [EMPTY_WIDTH-1:0]   src_empty_q, src_empty_d;
    logic [CHANNEL_WIDTH-1:0] src_channel_q, src_channel_d;
    logic                     wrken_q, wrken_d;

    logic                     sink_ready;
    logic                     sink_hs;
    logic [MAC_WIDTH-1:0]     sink_mac;
    logic                     hit_now;
    logic [LEN_SUM_W-1:0]     beat_len;
    logic [LEN_SUM_W-1:0]     len_sum;
    logic [LEN_WIDTH-1:0]     len_new;
    logic                     pkt_hit;
    logic                     pkt_end;
    logic                     fwd;
    logic                     accept_inc;
    logic                     reject_inc;
    logic                     len_err_inc;
    logic                     frame_err_inc;

    // rdy_en_q keeps the sink stalled until the first clock after reset release.
    assign sink_ready        = rdy_en_q & (~src_valid_q | ast_src_if.ready);
    assign ast_sink_if.ready = sink_ready;
    assign sink_hs           = ast_sink_if.valid & sink_ready;

    assign sink_mac = ast_sink_if.data[AST_DWIDTH-1 -: MAC_WIDTH];
    assign hit_now  = ~filter_en_i | (sink_mac == dst_mac_i) | (sink_mac == BCAST_MAC);

    always_comb begin
        beat_len = BEAT_LEN;
        if (ast_sink_if.endofpacket) begin
            beat_len = BEAT_LEN - LEN_SUM_W'(ast_sink_if.empty);
        end
        len_sum = (ast_sink_if.startofpacket ? '0 : {1'b0, len_q}) + beat_len;
        len_new = (len_sum > {1'b0, LEN_SAT}) ? LEN_SAT : len_sum[LEN_WIDTH-1:0];
    end

    always_comb begin
        state_d       = state_q;
        rdy_en_d      = 1'b1;
        len_d         = len_q;
        hit_d         = hit_q;
        src_data_d    = src_data_q;
        src_sop_d     = src_sop_q;
        src_eop_d     = src_eop_q;
        src_empty_d   = src_empty_q;
        src_channel_d = src_channel_q;
        src_valid_d   = src_valid_q & ~ast_src_if.ready;
        // The flag belongs to the packet on the output; it drops once its eop beat leaves.
        wrken_d       = (src_valid_q & ast_src_if.ready & src_eop_q) ? 1'b0 : wrken_q;
        pkt_hit       = hit_q;
        pkt_end       = 1'b0;
        fwd           = 1'b0;
        frame_err_inc = 1'b0;

        if (sink_hs) begin
            if ((state_q == ST_IDLE) && !ast_sink_if.startofpacket) begin
                frame_err_inc = 1'b1;
            end else begin
                fwd   = 1'b1;
                len_d = len_new;
                if ((state_q == ST_PKT) && ast_sink_if.startofpacket) begin
                    frame_err_inc = 1'b1;
                end
                if (ast_sink_if.startofpacket) begin
                    hit_d   = hit_now;
                    pkt_hit = hit_now;
                    wrken_d = hit_now;
                end
                if (ast_sink_if.endofpacket) begin
                    pkt_end = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PKT;
                end
            end
        end

        if (fwd) begin
            src_valid_d   = 1'b1;
            src_data_d    = ast_sink_if.data;
            src_sop_d     = ast_sink_if.startofpacket;
            src_eop_d     = ast_sink_if.endofpacket;
            src_empty_d   = ast_sink_if.empty;
            src_channel_d = ast_sink_if.channel;
        end

        accept_inc  = pkt_end & pkt_hit;
        reject_inc  = pkt_end & ~pkt_hit;
        len_err_inc = pkt_end & ((len_new < MIN_LEN) | (len_new > MAX_LEN));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            rdy_en_q      <= 1'b0;
            len_q         <= '0;
            hit_q         <= 1'b0;
            src_valid_q   <= 1'b0;
            src_data_q    <= '0;
            src_sop_q     <= 1'b0;
            src_eop_q     <= 1'b0;
            src_empty_q   <= '0;
            src_channel_q <= '0;
            wrken_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdy_en_q      <= rdy_en_d;
            len_q         <= len_d;
            hit_q         <= hit_d;
            src_valid_q   <= src_valid_d;
            src_data_q    <= src_data_d;
            src_sop_q     <= src_sop_d;
            src_eop_q     <= src_eop_d;
            src_empty_q   <= src_empty_d;
            src_channel_q <= src_channel_d;
            wrken_q       <= wrken_d;
        end
    end

    assign ast_src_if.valid         = src_valid_q;
    assign ast_src_if.data          = src_data_q;
    assign ast_src_if.startofpacket = src_sop_q;
    assign ast_src_if.endofpacket   = src_eop_q;
    assign ast_src_if.empty         = src_empty_q;
    assign ast_src_if.channel       = src_channel_q;
    assign wrken_o                  = wrken_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_accept_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (accept_inc),
        .count_o (accept_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_reject_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (reject_inc),
        .count_o (reject_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_len_err_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (len_err_inc),
        .count_o (len_err_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_err_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (frame_err_inc),
        .count_o (frame_err_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_ast_mac_filter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_ast_mac_filter : directed self-checking bench for ast_mac_filter.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_ast_mac_filter;

    localparam int DW = 64;

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  emp;
        logic        ch;
        logic        wr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        filter_en;
    logic [47:0] dst_mac;
    logic        wrken;
    logic [31:0] acc_cnt, rej_cnt, len_cnt, frm_cnt;

    logic        rdy_lvl;
    logic        bp_mode;
    logic [1:0]  bp_ph = 2'd0;

    int checks = 0;
    int errors = 0;
    int pkt_no = 0;

    avalon_st_if #(.DWIDTH(DW), .CHANNEL_WIDTH(1)) sink_if ();
    avalon_st_if #(.DWIDTH(DW), .CHANNEL_WIDTH(1)) src_if ();

    // Backpressure pattern 1,0,0,1 repeating.
    assign src_if.ready = bp_mode ? ((bp_ph == 2'd0) || (bp_ph == 2'd3)) : rdy_lvl;

    always #5 clk = ~clk;
    always @(posedge clk) bp_ph <= bp_ph + 2'd1;

    ast_mac_filter #(
        .AST_DWIDTH    (DW),
        .CHANNEL_WIDTH (1),
        .MIN_PCKT_SIZE (60),
        .MAX_PCKT_SIZE (1514),
        .CNT_WIDTH     (32)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .filter_en_i     (filter_en),
        .dst_mac_i       (dst_mac),
        .ast_sink_if     (sink_if),
        .ast_src_if      (src_if),
        .wrken_o         (wrken),
        .accept_cnt_o    (acc_cnt),
        .reject_cnt_o    (rej_cnt),
        .len_err_cnt_o   (len_cnt),
        .frame_err_cnt_o (frm_cnt)
    );

    // Output monitor: records every src handshake and watches stalled beats for stability.
    beat_t mon_q[$];
    beat_t exp_q[$];
    beat_t stall_snap;
    bit    stall_pend = 1'b0;
    int    stall_cnt  = 0;
    int    stall_viol = 0;
    int    mon_base   = 0;
    int    exp_base   = 0;

    always @(negedge clk) begin
        beat_t cur;
        cur = '{d: src_if.data, sop: src_if.startofpacket, eop: src_if.endofpacket,
                emp: src_if.empty, ch: src_if.channel[0], wr: wrken};
        if (stall_pend && (cur !== stall_snap)) stall_viol++;
        stall_pend = rst_n && src_if.valid && !src_if.ready;
        if (stall_pend) begin
            stall_snap = cur;
            stall_cnt++;
        end
        if (rst_n && src_if.valid && src_if.ready) mon_q.push_back(cur);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int a, input int r, input int l, input int f);
        check({tag, "_accept"}, 128'(acc_cnt), 128'(a));
        check({tag, "_reject"}, 128'(rej_cnt), 128'(r));
        check({tag, "_len_err"}, 128'(len_cnt), 128'(l));
        check({tag, "_frame_err"}, 128'(frm_cnt), 128'(f));
    endtask

    function automatic beat_t mk_beat(input logic [47:0] mac, input int pkt, input int idx,
                                      input int nb, input bit term, input logic [2:0] emp,
                                      input logic wr);
        beat_t b;
        b.d   = (idx == 0) ? {mac, 16'hA5A5} : {16'hBEEF, 32'(pkt), 16'(idx)};
        b.sop = (idx == 0);
        b.eop = term && (idx == nb - 1);
        b.emp = b.eop ? emp : 3'd0;
        b.ch  = pkt[0];
        b.wr  = wr;
        return b;
    endfunction

    // Called and returns at posedge+1 so consecutive beats go back-to-back.
    task automatic drive_beat(input beat_t b);
        int n;
        n = 0;
        sink_if.valid         = 1'b1;
        sink_if.data          = b.d;
        sink_if.startofpacket = b.sop;
        sink_if.endofpacket   = b.eop;
        sink_if.empty         = b.emp;
        sink_if.channel       = b.ch;
        @(negedge clk);
        while (!sink_if.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $error("FAIL hs_timeout: sink ready low for %0d cycles, required high within 100", n);
        end
        @(posedge clk);
        #1;
        sink_if.valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [47:0] mac, input int nb, input logic [2:0] emp,
                            input logic wr, input bit term, input bit lat_chk);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b = mk_beat(mac, pkt_no, i, nb, term, emp, wr);
            drive_beat(b);
            exp_q.push_back(b);
            if (lat_chk && i == 0) begin
                @(negedge clk);
                check("lat_src_valid", 128'(src_if.valid), 128'(1));
                check("lat_src_data", 128'(src_if.data), 128'(b.d));
                check("lat_src_sop", 128'(src_if.startofpacket), 128'(1));
                check("lat_wrken", 128'(wrken), 128'(1));
                @(posedge clk);
                #1;
            end
        end
        pkt_no++;
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        repeat (6) @(negedge clk);
        n = exp_q.size() - exp_base;
        check({tag, "_beats"}, 128'(mon_q.size() - mon_base), 128'(n));
        for (int i = 0; i < n; i++) begin
            if (mon_base + i < mon_q.size())
                check($sformatf("%s_beat%0d", tag, i), 128'(mon_q[mon_base + i]),
                      128'(exp_q[exp_base + i]));
        end
        mon_base = mon_q.size();
        exp_base = exp_q.size();
        @(posedge clk);
        #1;
    endtask

    localparam logic [47:0] MY_MAC   = 48'h0011_2233_4455;
    localparam logic [47:0] MISS_MAC = 48'h0011_2233_4456;
    localparam logic [47:0] BC_MAC   = 48'hFFFF_FFFF_FFFF;

    initial begin
        beat_t b;
        rst_n                 = 1'b0;
        filter_en             = 1'b1;
        dst_mac               = MY_MAC;
        rdy_lvl               = 1'b1;
        bp_mode               = 1'b0;
        sink_if.valid         = 1'b0;
        sink_if.data          = '0;
        sink_if.startofpacket = 1'b0;
        sink_if.endofpacket   = 1'b0;
        sink_if.empty         = '0;
        sink_if.channel       = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_src_valid", 128'(src_if.valid), 128'(0));
        check("rst_sink_ready", 128'(sink_if.ready), 128'(0));
        check("rst_wrken", 128'(wrken), 128'(0));
        chk_cnt("rst", 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_sink_ready", 128'(sink_if.ready), 128'(1));
        chk_cnt("idle", 0, 0, 0, 0);

        // MAC hit, 60 bytes
        send_pkt(MY_MAC, 8, 3'd4, 1'b1, 1'b1, 1'b1);
        cmp_stream("hit");
        check("hit_idle_wrken", 128'(wrken), 128'(0));
        chk_cnt("hit", 1, 0, 0, 0);

        send_pkt(MISS_MAC, 8, 3'd4, 1'b0, 1'b1, 1'b0);
        cmp_stream("miss");
        chk_cnt("miss", 1, 1, 0, 0);

        send_pkt(BC_MAC, 8, 3'd4, 1'b1, 1'b1, 1'b0);
        cmp_stream("bcast");
        chk_cnt("bcast", 2, 1, 0, 0);

        filter_en = 1'b0;
        send_pkt(48'hABCD_EF01_2345, 8, 3'd4, 1'b1, 1'b1, 1'b0);
        cmp_stream("nofilt");
        chk_cnt("nofilt", 3, 1, 0, 0);
        filter_en = 1'b1;

        // Backpressure: 1514 bytes legal, 1522 bytes too long
        bp_mode = 1'b1;
        send_pkt(MY_MAC, 190, 3'd6, 1'b1, 1'b1, 1'b0);
        cmp_stream("bp1514");
        chk_cnt("bp1514", 4, 1, 0, 0);
        send_pkt(MY_MAC, 191, 3'd6, 1'b1, 1'b1, 1'b0);
        cmp_stream("bp1522");
        chk_cnt("bp1522", 5, 1, 1, 0);
        bp_mode = 1'b0;
        check("stall_seen", 128'(stall_cnt > 0), 128'(1));
        check("stall_stable", 128'(stall_viol), 128'(0));

        // 59 bytes, then a single-beat 8-byte packet
        send_pkt(MY_MAC, 8, 3'd5, 1'b1, 1'b1, 1'b0);
        cmp_stream("short59");
        chk_cnt("short59", 6, 1, 2, 0);
        send_pkt(MY_MAC, 1, 3'd0, 1'b1, 1'b1, 1'b0);
        cmp_stream("single");
        chk_cnt("single", 7, 1, 3, 0);

        // Unterminated packet followed by a new (missed) packet
        send_pkt(MY_MAC, 3, 3'd0, 1'b1, 1'b0, 1'b0);
        send_pkt(MISS_MAC, 8, 3'd4, 1'b0, 1'b1, 1'b0);
        cmp_stream("unterm");
        chk_cnt("unterm", 7, 2, 3, 1);

        // Beat without sop in IDLE is dropped
        b = '{d: 64'hDEAD_BEEF_0000_0001, sop: 1'b0, eop: 1'b0, emp: 3'd0, ch: 1'b0, wr: 1'b0};
        drive_beat(b);
        cmp_stream("drop");
        chk_cnt("drop", 7, 2, 3, 2);

        // Asynchronous reset while beat 3 is presented
        for (int i = 0; i < 3; i++) begin
            b = mk_beat(MY_MAC, pkt_no, i, 8, 1'b1, 3'd4, 1'b1);
            drive_beat(b);
            if (i < 2) exp_q.push_back(b);
        end
        b = mk_beat(MY_MAC, pkt_no, 3, 8, 1'b1, 3'd4, 1'b1);
        pkt_no++;
        sink_if.valid         = 1'b1;
        sink_if.data          = b.d;
        sink_if.startofpacket = b.sop;
        sink_if.endofpacket   = b.eop;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_src_valid", 128'(src_if.valid), 128'(0));
        check("rstmid_src_data", 128'(src_if.data), 128'(0));
        check("rstmid_src_sop", 128'(src_if.startofpacket), 128'(0));
        check("rstmid_wrken", 128'(wrken), 128'(0));
        check("rstmid_sink_ready", 128'(sink_if.ready), 128'(0));
        chk_cnt("rstmid", 0, 0, 0, 0);
        sink_if.valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstrel_sink_ready", 128'(sink_if.ready), 128'(1));
        send_pkt(MY_MAC, 8, 3'd4, 1'b1, 1'b1, 1'b0);
        cmp_stream("post_rst");
        chk_cnt("post_rst", 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
